image_stream_tx: RTL and testbench

IMAGE_STREAM_TX -- requirements
Module: image_stream_tx

---
 rtl/image_stream_tx_if.sv | 25 ++
 rtl/image_stream_tx.sv | 219 +++++++++++++++++++++
 tb/tb_image_stream_tx.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/image_stream_tx_if.sv
// Bundle of frame-buffer read port, byte-stream output and control handshake for image_stream_tx.
// The master side is the transmitter; the slave side is its environment (frame buffer, sink, controller).
interface image_stream_tx_if #(
    parameter int ADDR_W = 17
) ();
    logic              start;
    logic              pix_rd_en;
    logic [ADDR_W-1:0] pix_addr;
    logic [7:0]        pix_data;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              busy;
    logic              done;

    modport master (
        input  start, pix_data, tx_ready,
        output pix_rd_en, pix_addr, tx_data, tx_valid, busy, done
    );

    modport slave (
        output start, pix_data, tx_ready,
        input  pix_rd_en, pix_addr, tx_data, tx_valid, busy, done
    );
endinterface

// File: rtl/image_stream_tx.sv
// Streams one frame as FF D8 <pixels with 0xFF->FF 00 stuffing> FF D9, prefetching pixels from a
// one-cycle-latency frame buffer through a two-entry buffer so a ready sink sees no bubbles.
module image_stream_tx #(
    parameter int IMG_WIDTH  = 320,
    parameter int IMG_HEIGHT = 240,
    parameter int ADDR_W     = 17
) (
    input  logic               clk,
    input  logic               reset,
    image_stream_tx_if.master  bus
);
    localparam int NPIX      = IMG_WIDTH * IMG_HEIGHT;
    localparam int LAST_ADDR = NPIX - 1;
    localparam int X_LAST    = IMG_WIDTH - 1;
    localparam int XW        = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int YW        = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int PW        = ADDR_W + 1;

    localparam logic [PW-1:0]     NPIX_C      = NPIX[PW-1:0];
    localparam logic [ADDR_W-1:0] LAST_ADDR_C = LAST_ADDR[ADDR_W-1:0];
    localparam logic [XW-1:0]     X_LAST_C    = X_LAST[XW-1:0];

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SOI_FF = 3'd1,
        SOI_D8 = 3'd2,
        DATA   = 3'd3,
        STUFF  = 3'd4,
        EOI_FF = 3'd5,
        EOI_D9 = 3'd6
    } state_t;

    state_t            state_q;
    logic [7:0]        tx_data_q;
    logic              tx_valid_q, busy_q, done_q, rd_en_q, inflight_q, rd_done_q;
    logic [ADDR_W-1:0] addr_q, nxt_addr_q;
    logic [XW-1:0]     x_q;
    logic [YW-1:0]     y_q;
    logic [7:0]        fifo0_q, fifo1_q;
    logic [1:0]        cnt_q;
    logic [PW-1:0]     pop_cnt_q;

    logic              xfer_s, avail_s, last_sent_s, load_s, pop_fifo_s, push_s, issue_s;
    logic [7:0]        head_s, fifo0_d, fifo1_d;
    logic [1:0]        cnt_d;
    logic [2:0]        tokens_s;
    logic [ADDR_W-1:0] cur_addr_s;
    logic [XW-1:0]     cur_x_s;
    logic [YW-1:0]     cur_y_s;

    // Pixel buffer bookkeeping: the in-flight read can bypass straight into the output byte register.
    always_comb begin
        xfer_s      = tx_valid_q & bus.tx_ready;
        avail_s     = (cnt_q != 2'd0) | inflight_q;
        head_s      = (cnt_q != 2'd0) ? fifo0_q : bus.pix_data;
        last_sent_s = (pop_cnt_q == NPIX_C);
        case (state_q)
            SOI_D8:  load_s = xfer_s & avail_s;
            DATA:    load_s = avail_s & ~last_sent_s & (~tx_valid_q | (xfer_s & (tx_data_q != 8'hFF)));
            STUFF:   load_s = xfer_s & avail_s & ~last_sent_s;
            default: load_s = 1'b0;
        endcase
        pop_fifo_s = load_s & (cnt_q != 2'd0);
        push_s     = inflight_q & ~(load_s & (cnt_q == 2'd0));
        fifo0_d    = fifo0_q;
        fifo1_d    = fifo1_q;
        if (pop_fifo_s) begin
            fifo0_d = fifo1_q;
        end else begin
            fifo0_d = fifo0_q;
        end
        if (push_s) begin
            if ((cnt_q - {1'b0, pop_fifo_s}) == 2'd0) begin
                fifo0_d = bus.pix_data;
            end else begin
                fifo1_d = bus.pix_data;
            end
        end else begin
            fifo1_d = fifo1_q;
        end
        cnt_d    = cnt_q - {1'b0, pop_fifo_s} + {1'b0, push_s};
        // Reads issued but not yet sent never exceed two, which bounds the buffer depth.
        tokens_s = {1'b0, cnt_q} + {2'b00, inflight_q} + {2'b00, rd_en_q} - {2'b00, load_s};
        if (state_q == IDLE) begin
            cur_addr_s = '0;
            cur_x_s    = '0;
            cur_y_s    = '0;
            issue_s    = bus.start;
        end else begin
            cur_addr_s = nxt_addr_q;
            cur_x_s    = x_q;
            cur_y_s    = y_q;
            issue_s    = ~rd_done_q & (tokens_s < 3'd2);
        end
    end

    // Frame FSM together with the read prefetcher and pixel buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_en_q    <= 1'b0;
            inflight_q <= 1'b0;
            rd_done_q  <= 1'b0;
            addr_q     <= '0;
            nxt_addr_q <= '0;
            x_q        <= '0;
            y_q        <= '0;
            fifo0_q    <= 8'h00;
            fifo1_q    <= 8'h00;
            cnt_q      <= 2'd0;
            pop_cnt_q  <= '0;
        end else begin
            done_q     <= 1'b0;
            rd_en_q    <= issue_s;
            inflight_q <= rd_en_q;
            fifo0_q    <= fifo0_d;
            fifo1_q    <= fifo1_d;
            cnt_q      <= cnt_d;
            if (issue_s) begin
                addr_q    <= cur_addr_s;
                rd_done_q <= (cur_addr_s == LAST_ADDR_C);
                if (cur_addr_s != LAST_ADDR_C) begin
                    nxt_addr_q <= cur_addr_s + ADDR_W'(1);
                    if (cur_x_s == X_LAST_C) begin
                        x_q <= '0;
                        y_q <= cur_y_s + YW'(1);
                    end else begin
                        x_q <= cur_x_s + XW'(1);
                    end
                end
            end
            if (load_s) begin
                tx_data_q  <= head_s;
                tx_valid_q <= 1'b1;
                pop_cnt_q  <= pop_cnt_q + PW'(1);
            end
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q    <= SOI_FF;
                        tx_data_q  <= 8'hFF;
                        tx_valid_q <= 1'b1;
                        busy_q     <= 1'b1;
                        pop_cnt_q  <= '0;
                    end else begin
                        tx_valid_q <= 1'b0;
                    end
                end
                SOI_FF: begin
                    if (xfer_s) begin
                        state_q   <= SOI_D8;
                        tx_data_q <= 8'hD8;
                    end
                end
                SOI_D8: begin
                    if (xfer_s) begin
                        state_q <= DATA;
                        if (!load_s) begin
                            tx_valid_q <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (load_s) begin
                        state_q <= DATA;
                    end else if (xfer_s && tx_data_q == 8'hFF) begin
                        state_q   <= STUFF;
                        tx_data_q <= 8'h00;
                    end else if (xfer_s && last_sent_s) begin
                        state_q   <= EOI_FF;
                        tx_data_q <= 8'hFF;
                    end else if (xfer_s) begin
                        tx_valid_q <= 1'b0;
                    end
                end
                STUFF: begin
                    if (xfer_s && last_sent_s) begin
                        state_q   <= EOI_FF;
                        tx_data_q <= 8'hFF;
                    end else if (xfer_s) begin
                        state_q <= DATA;
                        if (!load_s) begin
                            tx_valid_q <= 1'b0;
                        end
                    end
                end
                EOI_FF: begin
                    if (xfer_s) begin
                        state_q   <= EOI_D9;
                        tx_data_q <= 8'hD9;
                    end
                end
                EOI_D9: begin
                    if (xfer_s) begin
                        state_q    <= IDLE;
                        tx_data_q  <= 8'h00;
                        tx_valid_q <= 1'b0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.tx_data   = tx_data_q;
    assign bus.tx_valid  = tx_valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pix_rd_en = rd_en_q;
    assign bus.pix_addr  = addr_q;
endmodule

// File: tb/tb_image_stream_tx.sv
// Directed bench for image_stream_tx: a 4x2 frame under several pixel/ready patterns plus a default-size frame.
module tb_image_stream_tx;
    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    image_stream_tx_if #(.ADDR_W(3))  s ();
    image_stream_tx_if #(.ADDR_W(17)) big ();

    image_stream_tx #(.IMG_WIDTH(4), .IMG_HEIGHT(2), .ADDR_W(3)) dut_small (
        .clk(clk), .reset(rst), .bus(s));
    image_stream_tx dut_big (
        .clk(clk), .reset(rst), .bus(big));

    logic [7:0] mem [0:7];
    // Frame buffer model with one-cycle read latency; garbage when not reading.
    always @(posedge clk) s.pix_data <= s.pix_rd_en ? mem[s.pix_addr] : 8'hA5;

    int   checks = 0;
    int   errors = 0;
    bq_t  got, exp_a, exp_b;
    int   rd_cnt, dup, first_addr, gaps, stall_bad, done_cnt;
    logic [7:0] rd_seen;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_stream(input string tag, input bq_t exp);
        check({tag, "_len"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), got[i], exp[i]);
    endtask

    // Runs one frame on the small DUT, recording bytes, reads and handshake behaviour.
    task automatic run_frame(input int pct, input bit do_start, input bit extra, input bit chain);
        int cyc = 0, last_x = 0, done_cyc = -100, tail_x = 0, tail_d = 0;
        bit seen_done = 0, started = 0, prev_stall = 0;
        logic [7:0] prev_data = 8'h00;
        got.delete();
        rd_cnt = 0; dup = 0; first_addr = -1; gaps = 0; stall_bad = 0; done_cnt = 0; rd_seen = '0;
        if (do_start) begin
            s.start = 1'b1;
            tick();
            s.start = 1'b0;
            check("busy_rise", s.busy, 1);
        end
        while (!seen_done && cyc < 400) begin
            s.tx_ready = (int'($urandom_range(0, 99)) < pct);
            s.start    = extra && (cyc % 3 == 1);
            if (s.pix_rd_en) begin
                if (first_addr < 0) first_addr = int'(s.pix_addr);
                if (rd_seen[s.pix_addr]) dup++;
                rd_seen[s.pix_addr] = 1'b1;
                rd_cnt++;
            end
            if (prev_stall && (s.tx_data !== prev_data || s.tx_valid !== 1'b1)) stall_bad++;
            if (started && s.busy && !s.tx_valid) gaps++;
            if (s.tx_valid && s.tx_ready) begin
                got.push_back(s.tx_data);
                last_x = cyc;
                started = 1;
            end
            if (s.done) begin
                seen_done = 1;
                done_cnt++;
                done_cyc = cyc;
                if (chain) s.start = 1'b1;
            end
            prev_stall = s.tx_valid && !s.tx_ready;
            prev_data  = s.tx_data;
            tick();
            cyc++;
        end
        s.start = 1'b0;
        check("done_seen", seen_done, 1);
        check("done_delay", done_cyc - last_x, 1);
        if (chain) begin
            check("busy_chain", s.busy, 1);
        end else begin
            s.tx_ready = 1'b1;
            for (int i = 0; i < 4; i++) begin
                if (s.tx_valid) tail_x++;
                if (s.done) tail_d++;
                tick();
            end
            check("tail_bytes", tail_x, 0);
            check("tail_done", tail_d, 0);
        end
    endtask

    initial begin
        int n, cyc, bytes, rds, last, dn;
        exp_a = '{8'hFF, 8'hD8, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'hFF, 8'hD9};
        exp_b = '{8'hFF, 8'hD8, 8'h00, 8'hFF, 8'h00, 8'h11, 8'hFF, 8'h00, 8'hFF, 8'h00,
                  8'h22, 8'h33, 8'h44, 8'hFF, 8'hD9};
        s.start = 1'b0; s.tx_ready = 1'b1; rst = 1'b1;
        big.start = 1'b0; big.tx_ready = 1'b1; big.pix_data = 8'h80;
        for (int i = 0; i < 8; i++) mem[i] = 8'(i + 1);
        tick(); tick(); tick();
        check("rst_valid", s.tx_valid, 0);
        check("rst_busy", s.busy, 0);
        check("rst_done", s.done, 0);
        check("rst_rd_en", s.pix_rd_en, 0);
        check("rst_addr", s.pix_addr, 0);
        check("rst_data", s.tx_data, 8'h00);
        rst = 1'b0;
        tick();

        // Plain frame, sink always ready.
        run_frame(100, 1, 0, 0);
        check_stream("A", exp_a);
        check("A_gaps", gaps, 0);
        check("A_reads", rd_cnt, 8);
        check("A_dup", dup, 0);
        check("A_first_addr", first_addr, 0);
        check("A_done_cnt", done_cnt, 1);

        // Stuffing frame, always ready then 30% ready.
        mem = '{8'h00, 8'hFF, 8'h11, 8'hFF, 8'hFF, 8'h22, 8'h33, 8'h44};
        run_frame(100, 1, 0, 0);
        check_stream("B", exp_b);
        check("B_gaps", gaps, 0);
        check("B_reads", rd_cnt, 8);
        check("B_dup", dup, 0);
        run_frame(30, 1, 0, 0);
        check_stream("B30", exp_b);
        check("B30_stall", stall_bad, 0);
        check("B30_reads", rd_cnt, 8);
        check("B30_dup", dup, 0);

        // Starts during a frame ignored; start in the done cycle chains a second frame.
        for (int i = 0; i < 8; i++) mem[i] = 8'(i + 1);
        run_frame(100, 1, 1, 1);
        check_stream("X1", exp_a);
        check("X1_done_cnt", done_cnt, 1);
        run_frame(100, 0, 0, 0);
        check_stream("X2", exp_a);
        check("X2_gaps", gaps, 0);
        check("X2_first_addr", first_addr, 0);

        // Reset after the fifth byte, with start and ready also high in the reset cycle.
        s.start = 1'b1; tick(); s.start = 1'b0;
        s.tx_ready = 1'b1; n = 0; cyc = 0;
        while (n < 5 && cyc < 50) begin
            if (s.tx_valid) n++;
            tick();
            cyc++;
        end
        check("R_pre_bytes", n, 5);
        rst = 1'b1; s.start = 1'b1;
        tick();
        s.start = 1'b0;
        check("R_valid", s.tx_valid, 0);
        check("R_busy", s.busy, 0);
        check("R_rd_en", s.pix_rd_en, 0);
        check("R_addr", s.pix_addr, 0);
        check("R_data", s.tx_data, 8'h00);
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            if (s.tx_valid || s.busy) n++;
            tick();
        end
        check("R_quiet", n, 0);
        run_frame(100, 1, 0, 0);
        check_stream("R", exp_a);
        check("R_first_addr", first_addr, 0);
        check("R_reads", rd_cnt, 8);

        // Default-size frame of constant 0x80 pixels.
        big.start = 1'b1; tick(); big.start = 1'b0;
        bytes = 0; rds = 0; last = -1; dn = 0; cyc = 0;
        while (dn == 0 && cyc < 80000) begin
            if (big.tx_valid && big.tx_ready) bytes++;
            if (big.pix_rd_en) begin rds++; last = int'(big.pix_addr); end
            if (big.done) dn++;
            tick();
            cyc++;
        end
        for (int i = 0; i < 4; i++) begin
            if (big.done) dn++;
            if (big.pix_rd_en) rds++;
            tick();
        end
        check("BIG_bytes", bytes, 76804);
        check("BIG_reads", rds, 76800);
        check("BIG_last_addr", last, 76799);
        check("BIG_done", dn, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
